// File: rtl/minimax_mem_sys.sv
// Memory and exit subsystem for minimax: shared RAM, fetch register, console TX FIFO, exit/timeout.
// Define MINIMAX_CONSOLE_EN to build the console FIFO and its STATUS register.
module minimax_mem_sys #(
  parameter int unsigned MEM_BYTES = 4096,
  parameter int unsigned PC_BITS   = $clog2(MEM_BYTES),
  parameter string       INIT_FILE = "",
  parameter int unsigned MAXTICKS  = 100000,
  parameter int unsigned TX_DEPTH  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PC_BITS-1:0] inst_addr,
  input  logic               inst_regce,
  output logic [15:0]        inst,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  input  logic [3:0]         wmask,
  input  logic               rreq,
  output logic [31:0]        rdata,
  output logic               tx_valid,
  output logic [7:0]         tx_data,
  input  logic               tx_ready,
  output logic               done,
  output logic               timeout,
  output logic [31:0]        exit_code
);

  localparam int unsigned HWORDS = MEM_BYTES / 2;

  typedef enum logic [1:0] {
    REG_NONE   = 2'b00,
    REG_STATUS = 2'b01,
    REG_TX     = 2'b10,
    REG_EXIT   = 2'b11
  } mmio_reg_e;

  logic [15:0]        ram [0:HWORDS-1];
  logic [15:0]        inst_lat;
  logic [PC_BITS-2:0] lo_idx;
  logic [PC_BITS-2:0] hi_idx;
  logic               is_mmio;
  mmio_reg_e          mmio_sel;
  logic               ram_we;
  logic               exit_wr;
  logic               tick_hit;
  logic [31:0]        tick;
  logic [31:0]        status;
  logic [31:0]        mmio_rdata;
  logic               unused;

  assign is_mmio  = (addr[31:4] == 28'hFFFFFFF);
  assign mmio_sel = mmio_reg_e'(addr[3:2]);
  assign lo_idx   = {addr[PC_BITS-1:2], 1'b0};
  assign hi_idx   = {addr[PC_BITS-1:2], 1'b1};
  assign ram_we   = !is_mmio && !done;
  assign exit_wr  = is_mmio && (mmio_sel == REG_EXIT) && (wmask == 4'hF) && !done;
  assign tick_hit = (MAXTICKS != 0) && (tick == 32'(MAXTICKS));
  assign unused   = ^{addr[1:0], inst_addr[0]};

  always_ff @(posedge clk) begin
    if (ram_we) begin
      if (wmask[0]) ram[lo_idx][7:0]  <= wdata[7:0];
      if (wmask[1]) ram[lo_idx][15:8] <= wdata[15:8];
      if (wmask[2]) ram[hi_idx][7:0]  <= wdata[23:16];
      if (wmask[3]) ram[hi_idx][15:8] <= wdata[31:24];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inst_lat <= '0;
      inst     <= '0;
    end else begin
      inst_lat <= ram[inst_addr[PC_BITS-1:1]];
      if (inst_regce) inst <= inst_lat;
    end
  end

  always_comb begin
    mmio_rdata = '0;
    if (mmio_sel == REG_STATUS) mmio_rdata = status;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (rreq) begin
      rdata <= is_mmio ? mmio_rdata : {ram[hi_idx], ram[lo_idx]};
    end
  end

  // An EXIT write takes priority over a timeout landing in the same cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick      <= '0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      exit_code <= '0;
    end else if (!done) begin
      tick <= tick + 32'd1;
      if (exit_wr) begin
        done      <= 1'b1;
        exit_code <= wdata;
      end else if (tick_hit) begin
        done      <= 1'b1;
        timeout   <= 1'b1;
        exit_code <= '1;
      end
    end
  end

`ifdef MINIMAX_CONSOLE_EN
  localparam int unsigned AW = $clog2(TX_DEPTH);

  logic [7:0] fifo [0:TX_DEPTH-1];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        overflow;
  logic        full;
  logic        empty;
  logic        pop;
  logic        push_req;
  logic        push;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign tx_valid = !empty;
  assign tx_data  = empty ? '0 : fifo[rd_ptr[AW-1:0]];
  assign pop      = tx_valid && tx_ready;
  assign push_req = !done && is_mmio && (mmio_sel == REG_TX) && wmask[0];
  // A pop frees the head slot in the same cycle, so a full FIFO still accepts
  assign push     = push_req && (!full || pop);
  assign status   = {29'd0, overflow, empty, full};

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr[AW-1:0]] <= wdata[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push_req && !push) overflow <= 1'b1;
    end
  end
`else
  logic unused_console;

  assign tx_valid       = 1'b0;
  assign tx_data        = '0;
  assign status         = '0;
  assign unused_console = tx_ready;
`endif

endmodule

// File: tb/tb_minimax_mem_sys.sv
// Randomized and directed bench for minimax_mem_sys against a byte-array / queue reference model.
// Expectations follow MINIMAX_CONSOLE_EN when defined at compile time.
module tb_minimax_mem_sys;
  localparam int unsigned MEMB  = 1024;
  localparam int unsigned PCB   = 10;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMAX  = 50;
`ifdef MINIMAX_CONSOLE_EN
  localparam bit CON = 1'b1;
`else
  localparam bit CON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [PCB-1:0] inst_addr = '0;
  logic        inst_regce = 1'b0;
  logic [15:0] inst;
  logic [31:0] addr = '0, wdata = '0, rdata, exit_code;
  logic [3:0]  wmask = '0;
  logic        rreq = 1'b0, tx_ready = 1'b0;
  logic        tx_valid, done, timeout;
  logic [7:0]  tx_data;

  logic [31:0] t_addr = '0, t_wdata = '0, t_rdata, t_exit_code;
  logic [3:0]  t_wmask = '0;
  logic [15:0] t_inst;
  logic        t_tx_valid, t_done, t_timeout;
  logic [7:0]  t_tx_data;

  minimax_mem_sys #(.MEM_BYTES(MEMB), .PC_BITS(PCB), .MAXTICKS(0), .TX_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .inst_addr(inst_addr), .inst_regce(inst_regce), .inst(inst),
    .addr(addr), .wdata(wdata), .wmask(wmask), .rreq(rreq), .rdata(rdata),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .done(done), .timeout(timeout), .exit_code(exit_code));

  minimax_mem_sys #(.MEM_BYTES(MEMB), .PC_BITS(PCB), .MAXTICKS(TMAX), .TX_DEPTH(DEPTH)) dut_t (
    .clk(clk), .reset(reset), .inst_addr('0), .inst_regce(1'b0), .inst(t_inst),
    .addr(t_addr), .wdata(t_wdata), .wmask(t_wmask), .rreq(1'b0), .rdata(t_rdata),
    .tx_valid(t_tx_valid), .tx_data(t_tx_data), .tx_ready(1'b0),
    .done(t_done), .timeout(t_timeout), .exit_code(t_exit_code));

  // Reference model
  logic [7:0]  mem_m [MEMB];
  logic [7:0]  fq [$];
  bit          ovf_m, done_m;
  logic [31:0] exit_m, rdata_m;
  logic [15:0] lat_m, inst_m;

  int unsigned vectors = 0;
  int unsigned errs = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    int unsigned b;
    b = 32'(a[PCB-1:2]) * 4;
    return {mem_m[b+3], mem_m[b+2], mem_m[b+1], mem_m[b]};
  endfunction

  function automatic logic [15:0] rd_half(input logic [PCB-1:0] a);
    int unsigned b;
    b = 32'(a[PCB-1:1]) * 2;
    return {mem_m[b+1], mem_m[b]};
  endfunction

  task automatic check_all();
    check("inst", 32'(inst), 32'(inst_m));
    check("rdata", rdata, rdata_m);
    check("tx_valid", 32'(tx_valid), 32'(CON && fq.size() != 0));
    if (!CON || fq.size() != 0)
      check("tx_data", 32'(tx_data), 32'(fq.size() != 0 ? fq[0] : 8'h00));
    check("done", 32'(done), 32'(done_m));
    check("timeout", 32'(timeout), 32'd0);
    check("exit_code", exit_code, exit_m);
  endtask

  task automatic cycle();
    bit mmio, pop_m, push_m;
    logic [31:0] st;
    int unsigned base;
    mmio = (addr[31:4] == 28'hFFFFFFF);
    st = CON ? {29'd0, ovf_m, fq.size() == 0, fq.size() == DEPTH} : 32'd0;
    if (rreq) rdata_m = mmio ? ((addr[3:2] == 2'b01) ? st : 32'd0) : rd_word(addr);
    if (inst_regce) inst_m = lat_m;
    lat_m = rd_half(inst_addr);
    pop_m = CON && fq.size() != 0 && tx_ready;
    push_m = 1'b0;
    if (!done_m) begin
      if (!mmio) begin
        base = 32'(addr[PCB-1:2]) * 4;
        for (int unsigned b = 0; b < 4; b++)
          if (wmask[b]) mem_m[base+b] = wdata[8*b +: 8];
      end else if (addr[3:2] == 2'b10 && wmask[0] && CON) begin
        if (pop_m || fq.size() < DEPTH) push_m = 1'b1;
        else ovf_m = 1'b1;
      end else if (addr[3:2] == 2'b11 && wmask == 4'hF) begin
        done_m = 1'b1;
        exit_m = wdata;
      end
    end
    if (pop_m) void'(fq.pop_front());
    if (push_m) fq.push_back(wdata[7:0]);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    addr = '0; wdata = '0; wmask = '0; rreq = 1'b0; inst_regce = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    #1;
    check("rst_inst", 32'(inst), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_exit_code", exit_code, 32'd0);
    check("rst_t_done", 32'(t_done), 32'd0);
    check("rst_t_timeout", 32'(t_timeout), 32'd0);
    check("rst_t_tx_data", 32'(t_tx_data), 32'd0);
    fq.delete();
    ovf_m = 1'b0; done_m = 1'b0; exit_m = '0; rdata_m = '0; lat_m = '0; inst_m = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    addr = a; wdata = d; wmask = m; rreq = 1'b0;
    cycle();
    idle();
  endtask

  task automatic rd(input logic [31:0] a);
    addr = a; wmask = '0; rreq = 1'b1;
    cycle();
    idle();
  endtask

  initial begin
    do_reset();

    // Fill RAM so every model byte is known, using aliased upper address bits
    for (int unsigned w = 0; w < MEMB / 4; w++)
      wr((w * 4) | ($urandom & 32'h7FFF_FC00), $urandom, 4'hF);

    for (int i = 0; i < 400; i++) begin
      addr = $urandom;
      if (addr[31:4] == 28'hFFFFFFF) addr[31] = 1'b0;
      wdata = $urandom;
      wmask = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      rreq = 1'($urandom);
      inst_addr = PCB'($urandom) & ~PCB'(1);
      inst_regce = ($urandom_range(0, 3) != 0);
      cycle();
    end
    idle();

    wr(32'h100, 32'h11223344, 4'hF);
    wr(32'h100, 32'hAABBCCDD, 4'b0101);
    inst_addr = PCB'(10'h102);
    rd(32'h100);
    check("bytemask_read", rdata, 32'h11BB33DD);
    inst_regce = 1'b1;
    cycle();
    inst_regce = 1'b0;
    check("fetch_0x102", 32'(inst), 32'h11BB);

    do_reset();
    for (int i = 0; i < 5; i++) wr(32'hFFFF_FFF8, 32'h41 + i, 4'h1);
    rd(32'hFFFF_FFF4);
    check("status_overflow", rdata, CON ? 32'd5 : 32'd0);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    tx_ready = 1'b0;
    rd(32'hFFFF_FFF4);
    check("status_drained", rdata, CON ? 32'd6 : 32'd0);

    do_reset();
    for (int i = 0; i < 4; i++) wr(32'hFFFF_FFF8, 32'h41 + i, 4'hF);
    rd(32'hFFFF_FFF4);
    check("status_full", rdata, CON ? 32'd1 : 32'd0);
    tx_ready = 1'b1;
    wr(32'hFFFF_FFF8, 32'h55, 4'h1);
    tx_ready = 1'b0;
    rd(32'hFFFF_FFF4);
    check("full_push_pop", rdata, CON ? 32'd1 : 32'd0);
    tx_ready = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    tx_ready = 1'b0;

    for (int i = 0; i < 3; i++) wr(32'hFFFF_FFF8, 32'h61 + i, 4'h1);
    wr(32'hFFFF_FFFC, 32'd5, 4'b0111);
    check("exit_partial", 32'(done), 32'd0);
    wr(32'hFFFF_FFFC, 32'd0, 4'hF);
    check("exit_done", 32'(done), 32'd1);
    check("exit_code0", exit_code, 32'd0);
    check("exit_timeout", 32'(timeout), 32'd0);
    wr(32'h100, 32'hDEADBEEF, 4'hF);
    wr(32'hFFFF_FFF8, 32'h70, 4'h1);
    wr(32'hFFFF_FFFC, 32'd9, 4'hF);
    inst_addr = PCB'(10'h102);
    rd(32'h100);
    check("ram_after_done", rdata, 32'h11BB33DD);
    check("exit_sticky", exit_code, 32'd0);
    tx_ready = 1'b1;
    cycle();
    tx_ready = 1'b0;
    inst_regce = 1'b1;
    cycle();
    check("fetch_after_done", 32'(inst), 32'h11BB);

    do_reset();
    rd(32'h100);
    check("ram_survives_reset", rdata, 32'h11BB33DD);

    do_reset();
    begin
      bit seen = 1'b0;
      for (int k = 1; k <= 200 && !seen; k++) begin
        cycle();
        check("timeout_done_edge", 32'(t_done), 32'(k >= TMAX + 1));
        if (t_done) begin
          seen = 1'b1;
          check("timeout_flag", 32'(t_timeout), 32'd1);
          check("timeout_code", t_exit_code, 32'hFFFF_FFFF);
        end
      end
      check("timeout_seen", 32'(seen), 32'd1);
    end

    do_reset();
    for (int k = 1; k <= TMAX; k++) cycle();
    check("pre_tie_done", 32'(t_done), 32'd0);
    t_addr = 32'hFFFF_FFFC; t_wdata = 32'd7; t_wmask = 4'hF;
    cycle();
    check("tie_done", 32'(t_done), 32'd1);
    check("tie_code", t_exit_code, 32'd7);
    check("tie_timeout", 32'(t_timeout), 32'd0);
    t_wdata = 32'd9;
    cycle();
    t_wmask = '0;
    check("tie_sticky", t_exit_code, 32'd7);
    check("t_inst_idle", 32'(t_inst), 32'd0);
    check("t_rdata_idle", t_rdata, 32'd0);
    check("t_tx_valid_idle", 32'(t_tx_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
